// File: rtl/distance_bcd_formatter.sv
// Binary-to-BCD formatter for the 4-digit seven-segment driver: one-bit-per-clock
// double-dabble conversion followed by leading-zero blanking and overflow dashes.
module distance_bcd_formatter #(
    parameter int IN_W     = 14,
    parameter int MAX_VAL  = 9999,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] value,
    input  logic            value_vld,
    output logic            busy,
    output logic [15:0]     nums,
    output logic            nums_vld
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [15:0] NUMS_BLANK = 16'hBBBB;
    localparam logic [15:0] NUMS_DASH  = 16'hAAAA;

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    state_t            state, state_nxt;
    logic [IN_W-1:0]   shift_q;
    logic [15:0]       bcd_q;
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              last_shift;

    function automatic logic [15:0] add3_all(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Zero nibbles above the ones digit become blank until the first nonzero digit.
    function automatic logic [15:0] blank_lz(input logic [15:0] b);
        logic [15:0] r;
        logic        lead;
        r    = b;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (b[i*4 +: 4] == 4'd0))
                r[i*4 +: 4] = 4'hB;
            else
                lead = 1'b0;
        end
        return r;
    endfunction

    assign bcd_adj    = add3_all(bcd_q);
    assign last_shift = (cnt_q == CNT_W'(IN_W - 1));

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (value_vld) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = FORMAT;
            FORMAT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            nums     <= NUMS_BLANK;
            nums_vld <= 1'b0;
        end else begin
            nums_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (value_vld) begin
                        shift_q <= value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (32'(value) > 32'(MAX_VAL));
                    end
                end
                SHIFT: begin
                    bcd_q   <= {bcd_adj[14:0], shift_q[IN_W-1]};
                    shift_q <= {shift_q[IN_W-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                end
                FORMAT: begin
                    if (ovf_q)
                        nums <= NUMS_DASH;
                    else if (BLANK_LZ)
                        nums <= blank_lz(bcd_q);
                    else
                        nums <= bcd_q;
                    nums_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_distance_bcd_formatter.sv
// Randomized scoreboard bench for distance_bcd_formatter: two instances (blanking on/off)
// share stimulus; a monitor pops expected words and arrival cycles whenever nums_vld fires.
module tb_distance_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] value = '0;
    logic        value_vld = 1'b0;
    logic        busy1, busy0;
    logic [15:0] nums1, nums0;
    logic        nums_vld1, nums_vld0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] exp1;
        logic [15:0] exp0;
        int          at_cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    distance_bcd_formatter #(.IN_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .value_vld(value_vld),
        .busy(busy1), .nums(nums1), .nums_vld(nums_vld1)
    );

    distance_bcd_formatter #(.IN_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .value_vld(value_vld),
        .busy(busy0), .nums(nums0), .nums_vld(nums_vld0)
    );

    // Reference: decimal digits by division, dashes above 9999, blanking by magnitude.
    function automatic logic [15:0] model(input int v, input bit blank);
        logic [3:0] d3, d2, d1, d0;
        if (v > 9999) return 16'hAAAA;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        if (blank) begin
            if (v < 1000) d3 = 4'hB;
            if (v < 100)  d2 = 4'hB;
            if (v < 10)   d1 = 4'hB;
        end
        return {d3, d2, d1, d0};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called on a negedge; the request is captured at the next posedge.
    task automatic req(input logic [13:0] v);
        exp_t e;
        value     = v;
        value_vld = 1'b1;
        e.exp1    = model(int'(v), 1'b1);
        e.exp0    = model(int'(v), 1'b0);
        e.at_cyc  = cyc + 16;
        sb.push_back(e);
        @(negedge clk);
        value_vld = 1'b0;
        value     = 14'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst && (nums_vld1 || nums_vld0)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_nums_vld actual=%b/%b required=0/0 nums=%h", nums_vld1, nums_vld0, nums1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check16("nums_blank", nums1, e.exp1);
                check16("nums_noblank", nums0, e.exp0);
                check1("vld_pair", nums_vld1 & nums_vld0, 1'b1);
                checks++;
                if (cyc != e.at_cyc) begin
                    errors++;
                    $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, e.at_cyc);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [13:0] dir [7];
        dir = '{14'd1234, 14'd7, 14'd0, 14'd305, 14'd9999, 14'd10000, 14'd16383};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check16("reset_nums", nums1, 16'hBBBB);
            check16("reset_nums_nb", nums0, 16'hBBBB);
            check1("reset_busy", busy1, 1'b0);
            check1("reset_vld", nums_vld1, 1'b0);
        end

        foreach (dir[i]) begin
            req(dir[i]);
            repeat (5) @(negedge clk);
            check1("busy_mid", busy1, 1'b1);
            repeat (11) @(negedge clk);
            check1("busy_done", busy1, 1'b0);
        end

        // Request during busy is dropped; request in the nums_vld cycle is taken.
        req(14'd1234);
        repeat (3) @(negedge clk);
        check1("busy_drop", busy1, 1'b1);
        value = 14'd42;
        value_vld = 1'b1;
        @(negedge clk);
        value_vld = 1'b0;
        repeat (11) @(negedge clk);
        check1("vld_cycle_vld", nums_vld1, 1'b1);
        check1("vld_cycle_busy", busy1, 1'b0);
        req(14'd42);
        repeat (16) @(negedge clk);

        // Reset mid-conversion aborts and restores blanks.
        req(14'd4321);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        check1("abort_busy", busy1, 1'b0);
        check16("abort_nums", nums1, 16'hBBBB);
        check16("abort_nums_nb", nums0, 16'hBBBB);
        repeat (20) @(negedge clk);
        check16("abort_hold", nums1, 16'hBBBB);
        req(14'd58);
        repeat (16) @(negedge clk);

        for (int n = 0; n < 50; n++) begin
            logic [13:0] v;
            int gap;
            case ($urandom_range(0, 3))
                0:       v = 14'($urandom_range(0, 99));
                1:       v = 14'($urandom_range(9990, 10010));
                default: v = 14'($urandom_range(0, 16383));
            endcase
            req(v);
            gap = 15 + int'($urandom_range(0, 3));
            for (int k = 0; k < gap; k++) begin
                if (k < 13 && $urandom_range(0, 7) == 0) begin
                    value = 14'($urandom);
                    value_vld = 1'b1;
                end
                @(negedge clk);
                value_vld = 1'b0;
            end
        end

        repeat (20) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_results actual=%0d pending required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
